vector_decode_stage: RTL and testbench

//   Decode stage of the 3-lane vector pipeline. Extracts register source

---
 rtl/vector_decode_stage_if.sv | 29 ++
 rtl/vector_decode_stage.sv | 71 +++++++
 tb/tb_vector_decode_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_decode_stage_if.sv
// Decode-stage bus: fetch/control inputs, writeback port, and operand/immediate outputs.
// Master drives instruction, controls and writeback; slave is the decode stage.
interface vector_decode_stage_if #(
  parameter int LANES = 3,
  parameter int WIDTH = 18,
  parameter int AW    = 4
);
  logic                        RegWriteW;
  logic                        ImmSrcD;
  logic [31:0]                 Instr;
  logic [LANES-1:0][WIDTH-1:0] wd3;
  logic [AW-1:0]               wa3w;
  logic [2:0]                  RegSrc;
  logic [LANES-1:0][WIDTH-1:0] rd1;
  logic [LANES-1:0][WIDTH-1:0] rd2;
  logic [LANES-1:0][WIDTH-1:0] ExtImm;
  logic [AW-1:0]               ra1;
  logic [AW-1:0]               ra2;

  modport master (
    output RegWriteW, ImmSrcD, Instr, wd3, wa3w, RegSrc,
    input  rd1, rd2, ExtImm, ra1, ra2
  );

  modport slave (
    input  RegWriteW, ImmSrcD, Instr, wd3, wa3w, RegSrc,
    output rd1, rd2, ExtImm, ra1, ra2
  );
endinterface

// File: rtl/vector_decode_stage.sv
// Vector decode: 16 x 3-lane register file with write-through bypass, scalar broadcast and immediate extend.
// Latency 0 for reads, 1 edge for writes; no backpressure (every input is consumed each cycle).
module vector_decode_stage #(
  parameter int LANES = 3,
  parameter int WIDTH = 18,
  parameter int NREGS = 16
) (
  input logic                  clk,
  input logic                  reset,
  vector_decode_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  vec_t          regs [NREGS];
  logic [AW-1:0] ra1_i;
  logic [AW-1:0] ra2_i;
  vec_t          rd1_i;
  vec_t          rd2_raw;
  vec_t          rd2_i;
  vec_t          ext_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.RegWriteW) begin
      regs[bus.wa3w] <= bus.wd3;
    end
  end

  always_comb begin
    ra1_i = bus.RegSrc[0] ? AW'(NREGS - 1) : bus.Instr[16 +: AW];
    ra2_i = bus.RegSrc[1] ? bus.Instr[12 +: AW] : bus.Instr[0 +: AW];
  end

  // Outputs are forced to zero during reset so a pending write cannot leak through the bypass.
  always_comb begin
    rd1_i   = '0;
    rd2_raw = '0;
    if (!reset) begin
      rd1_i   = (bus.RegWriteW && (bus.wa3w == ra1_i)) ? bus.wd3 : regs[ra1_i];
      rd2_raw = (bus.RegWriteW && (bus.wa3w == ra2_i)) ? bus.wd3 : regs[ra2_i];
    end
  end

  always_comb begin
    rd2_i = rd2_raw;
    for (int i = 0; i < LANES; i++) begin
      if (bus.RegSrc[2]) begin
        rd2_i[i] = rd2_raw[0];
      end
    end
  end

  always_comb begin
    ext_i = '0;
    for (int i = 0; i < LANES; i++) begin
      ext_i[i] = bus.ImmSrcD ? {{(WIDTH-12){1'b0}}, bus.Instr[11:0]}
                             : {{(WIDTH-8){1'b0}}, bus.Instr[7:0]};
    end
  end

  assign bus.rd1    = rd1_i;
  assign bus.rd2    = rd2_i;
  assign bus.ExtImm = ext_i;
  assign bus.ra1    = ra1_i;
  assign bus.ra2    = ra2_i;
endmodule

// File: tb/tb_vector_decode_stage.sv
// Self-checking bench for vector_decode_stage: expected outputs queued at stimulus time, compared against sampled outputs.
module tb_vector_decode_stage;
  typedef logic [2:0][17:0] vec_t;
  typedef struct {
    string        name;
    logic [169:0] val;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  logic [169:0] obs_q[$];

  localparam vec_t Z  = '0;
  localparam vec_t V1 = {18'h20000, 18'h3FFFF, 18'h2AAAA};
  localparam vec_t V3 = {18'h2AA02, 18'h381FF, 18'h2BFFA};
  localparam vec_t VF = {18'h00001, 18'h12345, 18'h3C3C3};
  localparam vec_t VB = {18'h00001, 18'h00002, 18'h3FFFE};
  localparam logic [31:0] I0 = 32'hE0812003;
  localparam logic [31:0] I1 = 32'hE0812ABC;

  vector_decode_stage_if bus ();

  vector_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t rep(input logic [17:0] v);
    return {v, v, v};
  endfunction

  task automatic push_exp(input string n, input vec_t r1, input vec_t r2, input vec_t e,
                          input logic [3:0] a1, input logic [3:0] a2);
    rec_t r;
    r.name = n;
    r.val  = {r1, r2, e, a1, a2};
    exp_q.push_back(r);
  endtask

  task automatic snap();
    #1;
    obs_q.push_back({bus.rd1, bus.rd2, bus.ExtImm, bus.ra1, bus.ra2});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.RegWriteW = 1'b0;
    bus.ImmSrcD = 1'b0;
    bus.Instr = I0;
    bus.RegSrc = 3'b000;
    bus.wa3w = 4'd0;
    bus.wd3 = Z;
    tick();
    tick();
    push_exp("reset_active", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    @(negedge clk);
    reset = 1'b0;
    push_exp("reset_released", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    while (exp_q.size() > 0) begin
      rec_t e;
      logic [169:0] o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    bus.RegWriteW = 1'b0;
    bus.wa3w = 4'd1;
    bus.wd3 = V1;
    push_exp("nowr_r1_pre", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    tick();
    push_exp("nowr_r1_post", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    @(negedge clk);
    bus.wa3w = 4'd3;
    tick();
    push_exp("nowr_r3_post", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    @(negedge clk);
    bus.wa3w = 'x;
    bus.wd3 = 'x;
    tick();
    tick();
    push_exp("nowr_x_inputs", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    while (exp_q.size() > 0) begin
      rec_t e;
      logic [169:0] o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_write_r1();
    @(negedge clk);
    bus.RegWriteW = 1'b1;
    bus.wa3w = 4'd1;
    bus.wd3 = V1;
    push_exp("bypass_r1", V1, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    tick();
    bus.RegWriteW = 1'b0;
    bus.wa3w = 'x;
    bus.wd3 = 'x;
    push_exp("commit_r1", V1, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    while (exp_q.size() > 0) begin
      rec_t e;
      logic [169:0] o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_write_r3_broadcast();
    @(negedge clk);
    bus.RegWriteW = 1'b1;
    bus.wa3w = 4'd3;
    bus.wd3 = V3;
    push_exp("bypass_r3", V1, V3, rep(18'h3), 4'd1, 4'd3);
    snap();
    tick();
    bus.RegWriteW = 1'b0;
    bus.wa3w = 'x;
    bus.wd3 = 'x;
    push_exp("commit_r3", V1, V3, rep(18'h3), 4'd1, 4'd3);
    snap();
    bus.RegSrc = 3'b100;
    push_exp("broadcast_r3", V1, rep(18'h2BFFA), rep(18'h3), 4'd1, 4'd3);
    snap();
    @(negedge clk);
    bus.RegWriteW = 1'b1;
    bus.wa3w = 4'd3;
    bus.wd3 = VB;
    push_exp("broadcast_bypass", V1, rep(18'h3FFFE), rep(18'h3), 4'd1, 4'd3);
    snap();
    // Withdraw the write before the edge so r3 must keep its committed value.
    bus.RegWriteW = 1'b0;
    bus.RegSrc = 3'b000;
    tick();
    push_exp("r3_kept", V1, V3, rep(18'h3), 4'd1, 4'd3);
    snap();
    while (exp_q.size() > 0) begin
      rec_t e;
      logic [169:0] o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_imm_regsrc();
    @(negedge clk);
    bus.Instr = I1;
    bus.ImmSrcD = 1'b0;
    bus.RegSrc = 3'b000;
    push_exp("imm8", V1, Z, rep(18'h0BC), 4'd1, 4'd12);
    snap();
    bus.ImmSrcD = 1'b1;
    push_exp("imm12", V1, Z, rep(18'hABC), 4'd1, 4'd12);
    snap();
    bus.RegSrc = 3'b011;
    push_exp("regsrc_011", Z, Z, rep(18'hABC), 4'd15, 4'd2);
    snap();
    @(negedge clk);
    bus.RegWriteW = 1'b1;
    bus.wa3w = 4'd15;
    bus.wd3 = VF;
    tick();
    bus.RegWriteW = 1'b0;
    bus.wa3w = 'x;
    bus.wd3 = 'x;
    push_exp("r15_storage", VF, Z, rep(18'hABC), 4'd15, 4'd2);
    snap();
    while (exp_q.size() > 0) begin
      rec_t e;
      logic [169:0] o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    bus.Instr = I0;
    bus.ImmSrcD = 1'b0;
    bus.RegSrc = 3'b000;
    reset = 1'b1;
    bus.RegWriteW = 1'b1;
    bus.wa3w = 4'd1;
    bus.wd3 = V3;
    push_exp("reset_bypass_off", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    tick();
    reset = 1'b0;
    bus.RegWriteW = 1'b0;
    bus.wa3w = 'x;
    bus.wd3 = 'x;
    push_exp("reset_clears_r1_r3", Z, Z, rep(18'h3), 4'd1, 4'd3);
    snap();
    bus.RegSrc = 3'b001;
    push_exp("reset_clears_r15", Z, Z, rep(18'h3), 4'd15, 4'd3);
    snap();
    while (exp_q.size() > 0) begin
      rec_t e;
      logic [169:0] o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, o, e.val);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.RegWriteW = 1'b0;
    bus.ImmSrcD = 1'b0;
    bus.Instr = I0;
    bus.RegSrc = 3'b000;
    bus.wa3w = 4'd0;
    bus.wd3 = Z;
    test_reset();
    test_no_write();
    test_write_r1();
    test_write_r3_broadcast();
    test_imm_regsrc();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
